// File: rtl/mul_iter.sv
// mul_iter: iterative 64x64 -> 128-bit multiplier with optional signed operands.
// One radix-2 shift-add step per BUSY cycle: the operand magnitudes multiply
// unsigned, and the sign is applied once, when the product is complete.
// Optional feature macro: MUL_EARLY_OUT_EN. When it is defined, the block
// finishes as soon as the remaining multiplier bits are all zero.
//
// Handshake: a request transfers on a rising edge with in_valid=1 and
// in_ready=1 (IDLE only). A result transfers on a rising edge with
// out_valid=1 and out_ready=1 (DONE only). flush=1 or reset kills either
// transfer and any operation in flight.
module mul_iter (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] src_a,
    input  logic [63:0] src_b,
    input  logic        a_signed,
    input  logic        b_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result_hi,
    output logic [63:0] result_lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [127:0]  acc_q, acc_d;
    logic [63:0]   mcand_q, mcand_d;
    logic [63:0]   mplier_q, mplier_d;
    logic          neg_q, neg_d;

    logic [63:0]   addend;
    logic [64:0]   sum;
    logic [127:0]  step_acc;
    logic [127:0]  aligned;
    logic [127:0]  final_acc;
    logic          last_step;

    // Magnitude of a 64-bit operand; the most negative value maps to 2^63 unsigned.
    function automatic logic [63:0] magnitude(input logic [63:0] x, input logic is_signed);
        magnitude = (is_signed && x[63]) ? (~x + 64'd1) : x;
    endfunction

    // 64-bit carry-lookahead adder: 4-bit lookahead groups whose group
    // generate/propagate terms produce each group's carry-out directly.
    function automatic logic [64:0] cla_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] g;
        logic [63:0] p;
        logic [64:0] c;
        logic [15:0] gg;
        logic [15:0] gp;
        g = a & b;
        p = a ^ b;
        c = '0;
        for (int k = 0; k < 16; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        for (int k = 0; k < 16; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
        cla_add = {c[64], p ^ c[63:0]};
    endfunction

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the 129-bit result right by one.
    always_comb begin
        addend    = mplier_q[0] ? mcand_q : 64'd0;
        sum       = cla_add(acc_q[127:64], addend);
        step_acc  = {sum, acc_q[63:1]};
        last_step = (cnt_q == 6'd63);
`ifdef MUL_EARLY_OUT_EN
        // Remaining steps would only shift; apply those 63-cnt shifts at once.
        if (mplier_q[63:1] == 63'd0) begin
            last_step = 1'b1;
        end
        aligned = step_acc >> (~cnt_q);
`else
        aligned = step_acc;
`endif
        final_acc = neg_q ? (~aligned + 128'd1) : aligned;
    end

    // Next-state and datapath register updates; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d  = ST_BUSY;
                    cnt_d    = 6'd0;
                    acc_d    = 128'd0;
                    mcand_d  = magnitude(src_a, a_signed);
                    mplier_d = magnitude(src_b, b_signed);
                    neg_d    = (a_signed & src_a[63]) ^ (b_signed & src_b[63]);
                end
            end
            ST_BUSY: begin
                cnt_d    = cnt_q + 6'd1;
                mplier_d = {1'b0, mplier_q[63:1]};
                if (last_step) begin
                    acc_d   = final_acc;
                    state_d = ST_DONE;
                end else begin
                    acc_d = step_acc;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 6'd0;
                    acc_d    = 128'd0;
                    mcand_d  = 64'd0;
                    mplier_d = 64'd0;
                    neg_d    = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = 6'd0;
            acc_d    = 128'd0;
            mcand_d  = 64'd0;
            mplier_d = 64'd0;
            neg_d    = 1'b0;
        end
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 128'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 64'd0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
        end
    end

    // Handshake flags and zero-gated result outputs.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result_hi = out_valid ? acc_q[127:64] : 64'd0;
        result_lo = out_valid ? acc_q[63:0]   : 64'd0;
    end

endmodule

// File: doc/mul_iter.md
MUL_ITER -- requirements
Module: mul_iter

Interface
REQ-001 The block SHALL have these ports: clock (in, 1), the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have these ports: reset (in, 1), asynchronous, active-high.
REQ-003 The block SHALL have these ports: flush (in, 1), pipeline kill; aborts any operation.
REQ-004 The block SHALL have these ports: in_valid (in, 1), request present.
REQ-005 The block SHALL have these ports: in_ready (out, 1), block can accept a request.
REQ-006 The block SHALL have these ports: src_a, src_b (in, 64 each), multiplicand and multiplier.
REQ-007 The block SHALL have these ports: a_signed, b_signed (in, 1 each), treat src_a / src_b as two's complement.
REQ-008 The block SHALL have these ports: out_valid (out, 1), result present.
REQ-009 The block SHALL have these ports: out_ready (in, 1), consumer takes the result.
REQ-010 The block SHALL have these ports: result_hi, result_lo (out, 64 each), upper and lower halves of the 128-bit product.

Function
REQ-011 The block SHALL implement three states: IDLE, BUSY, DONE.
REQ-012 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-013 A request SHALL be accepted on a rising edge where IDLE, in_valid=1 and flush=0; the state then goes to BUSY with the iteration counter at 0.
REQ-014 On acceptance the block SHALL latch |src_a| and |src_b|, where a magnitude is taken only if the matching signed flag is set and bit 63 is 1; otherwise the raw value is latched.
REQ-015 On acceptance the block SHALL latch neg = (a_signed & src_a[63]) XOR (b_signed & src_b[63]).
REQ-016 Each BUSY edge SHALL process one multiplier bit, LSB first, as a radix-2 shift-add into a 128-bit accumulator; the 64-bit add SHALL use the team's carry-lookahead adder datapath.
REQ-017 After the 64th BUSY edge the state SHALL go to DONE, with a 128-bit two's-complement negation of the accumulator applied if neg=1.
REQ-018 Latency from the accept edge to out_valid=1 SHALL be 65 cycles when the early-out feature is off.
REQ-019 In DONE, result_hi/result_lo SHALL be held stable until an edge with out_ready=1; that edge SHALL return the state to IDLE.
REQ-020 A new request SHALL NOT be accepted on the same edge that retires a result, because in_ready is 0 in DONE.
REQ-021 flush=1 on any edge SHALL force IDLE and discard all internal state; flush has priority over acceptance and retirement.
REQ-022 result_hi/result_lo SHALL read 0 whenever out_valid=0.
REQ-023 Inputs SHALL be ignored outside IDLE; changes to src_a or src_b while BUSY SHALL NOT affect the result.
REQ-024 The most-negative value (0x8000_0000_0000_0000, signed) SHALL multiply correctly, its magnitude being treated as unsigned 2^63.

Reset
REQ-025 On reset assertion the block SHALL immediately go to IDLE, with counter, accumulator, operands and neg cleared.
REQ-026 During reset, in_ready SHALL be 1, out_valid 0, and result_hi/result_lo 0.
REQ-027 Reset mid-BUSY or in DONE SHALL discard the operation with no output.

Configuration
REQ-028 With MUL_EARLY_OUT_EN defined, BUSY SHALL go to DONE on the edge after which the remaining unshifted multiplier bits are all zero, with the accumulator shifted into final alignment on that edge.
REQ-029 With MUL_EARLY_OUT_EN defined, a multiplier magnitude of 0 SHALL complete after 1 BUSY edge.
REQ-030 Without MUL_EARLY_OUT_EN, every operation SHALL take exactly 64 BUSY edges.
REQ-031 Results SHALL be identical with and without MUL_EARLY_OUT_EN; only latency differs.

Verification
REQ-032 Scenario: unsigned 3 x 5, out_ready=1 -> result_lo=15, result_hi=0, out_valid rises 65 cycles after accept.
REQ-033 Scenario: signed -2 x 3 -> result_hi=0xFFFF_FFFF_FFFF_FFFF, result_lo=0xFFFF_FFFF_FFFF_FFFA.
REQ-034 Scenario: unsigned 0xFFFF_FFFF_FFFF_FFFF squared -> result_hi=0xFFFF_FFFF_FFFF_FFFE, result_lo=1; signed 0x8000_0000_0000_0000 squared -> result_hi=0x4000_0000_0000_0000, result_lo=0.
REQ-035 Scenario: out_ready held 0 for 10 cycles in DONE -> result held, in_ready=0, no new accept; retire on the first out_ready=1 edge.
REQ-036 Scenario: flush at BUSY iteration 20, with in_valid=1 on the same edge -> IDLE, no out_valid, request not accepted; next request computes correctly.
REQ-037 Scenario: MUL_EARLY_OUT_EN defined, unsigned 7 x 1 -> result_lo=7 with out_valid 2 cycles after accept; reset asserted mid-BUSY -> IDLE at once, outputs 0.
